// File: rtl/beam_threshold_loader.sv
`default_nettype none
// ============================================================================
// Module      : beam_threshold_loader
// Description : Source end of the beamformer threshold interface. Keeps a
//               shadow threshold per beam, writable at any time. On commit it
//               scans every beam once and presents each dirty threshold with
//               a one-hot CE. It then pulses update so all beams switch to
//               their new thresholds together.
//               Optional feature macro: THRESH_READBACK_EN (adds a registered
//               shadow readback port rd_beam_i / rd_thresh_o).
// Revision    : 1.0 - initial release
// ============================================================================
module beam_threshold_loader #(
    parameter int                  NBEAMS       = 46,
    parameter int                  THRESH_W     = 18,
    parameter logic [THRESH_W-1:0] THRESH_RESET = THRESH_W'(4000),
    localparam int                 BEAM_IDX_W   = $clog2(NBEAMS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_i,
    input  logic [BEAM_IDX_W-1:0] wr_beam_i,
    input  logic [THRESH_W-1:0]   wr_thresh_i,
    input  logic                  commit_i,
    output logic [THRESH_W-1:0]   thresh_o,
    output logic [NBEAMS-1:0]     thresh_ce_o,
    output logic                  update_o,
    output logic                  busy_o,
    output logic                  wr_err_o
`ifdef THRESH_READBACK_EN
    ,
    input  logic [BEAM_IDX_W-1:0] rd_beam_i,
    output logic [THRESH_W-1:0]   rd_thresh_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_UPDATE = 2'd2
    } state_t;

    localparam logic [BEAM_IDX_W-1:0] c_LAST_BEAM = BEAM_IDX_W'(NBEAMS - 1);
    localparam logic [BEAM_IDX_W-1:0] c_PTR_ONE   = BEAM_IDX_W'(1);
    localparam logic [NBEAMS-1:0]     c_CE_ONE    = NBEAMS'(1);

    state_t                r_state;
    logic [BEAM_IDX_W-1:0] r_ptr;
    logic                  r_commit_pend;
    logic [THRESH_W-1:0]   r_shadow [NBEAMS];
    logic [NBEAMS-1:0]     r_dirty;
    logic [THRESH_W-1:0]   r_thresh;
    logic [NBEAMS-1:0]     r_ce;
    logic                  r_update;
    logic                  r_busy;
    logic                  r_wr_err;

    logic                  w_start;
    logic                  w_scan;
    logic [BEAM_IDX_W-1:0] w_scan_idx;
    logic                  w_wr_in_range;
    logic                  w_wr_ok;

    // Scan selection: the commit edge itself scans beam 0, later LOAD edges scan r_ptr
    always_comb begin
        w_start       = (r_state == S_IDLE) && (commit_i || r_commit_pend);
        w_scan        = w_start || (r_state == S_LOAD);
        w_scan_idx    = w_start ? '0 : r_ptr;
        w_wr_in_range = (32'(wr_beam_i) < 32'(NBEAMS));
        w_wr_ok       = wr_i && w_wr_in_range;
    end

    // Sequencer, shadow/dirty bookkeeping and registered interface outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_commit_pend <= 1'b0;
            r_dirty       <= '1;
            r_thresh      <= '0;
            r_ce          <= '0;
            r_update      <= 1'b0;
            r_busy        <= 1'b0;
            r_wr_err      <= 1'b0;
            for (int i = 0; i < NBEAMS; i++) begin
                r_shadow[i] <= THRESH_RESET;
            end
        end else begin
            r_ce     <= '0;
            r_update <= 1'b0;
            r_wr_err <= wr_i && !w_wr_in_range;

            case (r_state)
                S_IDLE: begin
                    // The update cycle is spent here, so a pending commit
                    // restarts without an idle gap
                    if (w_start) begin
                        r_state       <= S_LOAD;
                        r_ptr         <= c_PTR_ONE;
                        r_commit_pend <= 1'b0;
                        r_busy        <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (commit_i) begin
                        r_commit_pend <= 1'b1;
                    end
                    if (r_ptr == c_LAST_BEAM) begin
                        r_state <= S_UPDATE;
                    end else begin
                        r_ptr <= r_ptr + c_PTR_ONE;
                    end
                end
                S_UPDATE: begin
                    if (commit_i) begin
                        r_commit_pend <= 1'b1;
                    end
                    r_update <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Scanned beam uses the shadow value from before this edge
            if (w_scan && r_dirty[w_scan_idx]) begin
                r_thresh             <= r_shadow[w_scan_idx];
                r_ce                 <= c_CE_ONE << w_scan_idx;
                r_dirty[w_scan_idx]  <= 1'b0;
            end

            // A write always wins over the scan's dirty clear, so a value
            // written while its beam is scanned goes out on the next commit
            if (w_wr_ok) begin
                r_shadow[wr_beam_i] <= wr_thresh_i;
                r_dirty[wr_beam_i]  <= 1'b1;
            end
        end
    end

`ifdef THRESH_READBACK_EN
    logic [THRESH_W-1:0] r_rd_thresh;

    // Registered shadow readback; out-of-range beams read as zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_thresh <= '0;
        end else if (32'(rd_beam_i) < 32'(NBEAMS)) begin
            r_rd_thresh <= r_shadow[rd_beam_i];
        end else begin
            r_rd_thresh <= '0;
        end
    end

    assign rd_thresh_o = r_rd_thresh;
`endif

    assign thresh_o    = r_thresh;
    assign thresh_ce_o = r_ce;
    assign update_o    = r_update;
    assign busy_o      = r_busy;
    assign wr_err_o    = r_wr_err;

endmodule
`default_nettype wire
